// File: rtl/i2c_pkg.sv
// Shared types for the I2C master arbitration slice.
// Command bundle, FSM state encoding and bus field widths.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_GAP
   } arb_state_t;

   typedef struct packed {
      logic                  wr;
      logic [I2C_ADDR_W-1:0] addr;
      logic [I2C_DATA_W-1:0] data;
   } i2c_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping at NUM_REQ-1 back to 0 (works for non-power-of-two counts).
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_req
);

   logic found;

   always_comb begin : pick
      int j;
      j            = 0;
      found        = 1'b0;
      grant_onehot = '0;
      grant_idx    = '0;
      any_req      = |req;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(rr_ptr) + i) % NUM_REQ;
         if (!found && req[j]) begin
            found           = 1'b1;
            grant_onehot[j] = 1'b1;
            grant_idx       = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master between NUM_REQ requesters: round-robin grant,
// command hold until done, one-hot completion pulse and a done watchdog.
module i2c_bus_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int GAP_CYCLES     = 4,
   localparam int IDX_W = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_wr,
   input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic                       resp_err,
   output logic [I2C_DATA_W-1:0]      resp_rdata,
   output logic                       busy,
   output logic [IDX_W-1:0]           grant_id,
   output logic                       m_newd,
   output logic                       m_wr,
   output logic [I2C_ADDR_W-1:0]      m_addr,
   output logic [I2C_DATA_W-1:0]      m_wdata,
   input  logic [I2C_DATA_W-1:0]      m_rdata,
   input  logic                       m_done
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GP_W = $clog2(GAP_CYCLES + 1);

   arb_state_t state, state_nx;

   logic [IDX_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] pick_oh;
   logic [NUM_REQ-1:0] grant_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               any_req;
   i2c_cmd_t           pick_cmd;
   i2c_cmd_t           cmd;
   logic [WD_W-1:0]    wd_cnt;
   logic [GP_W-1:0]    gap_cnt;
   logic               done_q;
   logic               done_rise;
   logic               wd_expired;
   logic               gap_last;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_rr (
      .req         (req),
      .rr_ptr      (rr_ptr),
      .grant_onehot(pick_oh),
      .grant_idx   (pick_idx),
      .any_req     (any_req)
   );

   always_comb begin
      pick_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) begin
            pick_cmd.wr   = req_wr[i];
            pick_cmd.addr = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
            pick_cmd.data = req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
         end
      end
   end

   assign done_rise  = m_done & ~done_q;
   assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign gap_last   = (gap_cnt == GP_W'(GAP_CYCLES - 1));

   assign busy    = (state != ST_IDLE);
   assign m_wr    = cmd.wr;
   assign m_addr  = cmd.addr;
   assign m_wdata = cmd.data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:  if (any_req) state_nx = ST_ISSUE;
         ST_ISSUE: state_nx = ST_WAIT;
         ST_WAIT:  if (done_rise || wd_expired) state_nx = ST_RESP;
         ST_RESP:  state_nx = ST_GAP;
         ST_GAP:   if (gap_last) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= '0;
         grant_id   <= '0;
         grant_oh   <= '0;
         cmd        <= '0;
         m_newd     <= 1'b0;
         wd_cnt     <= '0;
         gap_cnt    <= '0;
         done_q     <= 1'b0;
         resp_valid <= '0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= '0;
         unique case (state)
            ST_IDLE: begin
               if (any_req) begin
                  cmd      <= pick_cmd;
                  grant_id <= pick_idx;
                  grant_oh <= pick_oh;
               end
            end
            ST_ISSUE: begin
               m_newd <= 1'b1;
               wd_cnt <= '0;
               done_q <= m_done;
            end
            ST_WAIT: begin
               done_q <= m_done;
               if (wd_cnt != WD_W'(TIMEOUT_CYCLES))
                  wd_cnt <= wd_cnt + WD_W'(1);
               // a done edge on the expiry cycle still counts as success
               if (done_rise) begin
                  m_newd     <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= cmd.wr ? '0 : m_rdata;
               end else if (wd_expired) begin
                  m_newd     <= 1'b0;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end
            end
            ST_RESP: begin
               resp_valid <= grant_oh;
               gap_cnt    <= '0;
               rr_ptr     <= (grant_id == IDX_W'(NUM_REQ - 1)) ?
                             '0 : grant_id + IDX_W'(1);
            end
            ST_GAP: gap_cnt <= gap_cnt + GP_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one i2c_design master between NUM_REQ independent requesters.
- Grants requesters round-robin and drives the master's newd/wr/addr/wdata strobe interface.
- Holds the command until the master's done, then returns rdata and a one-hot completion pulse to the winner.
- A watchdog aborts transactions whose done never arrives and flags an error; sits between the register/host blocks and the single I2C master.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- TIMEOUT_CYCLES, 4096, max clk cycles in WAIT before abort (>=16).
- GAP_CYCLES, 4, idle cycles forced between back-to-back master commands (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until its resp_valid bit.
- req_wr  in  NUM_REQ  per-requester direction, 1=write 0=read.
- req_addr  in  NUM_REQ*7  packed 7-bit slave addresses, requester i at [7i+6:7i].
- req_wdata  in  NUM_REQ*8  packed write data, requester i at [8i+7:8i].
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; 1=timeout abort.
- resp_rdata  out  8  read data; valid with resp_valid for reads, 0 on writes/errors.
- busy  out  1  high in any state but IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of current/last winner.
- m_newd  out  1  command strobe to master.
- m_wr  out  1  direction to master.
- m_addr  out  7  slave address to master.
- m_wdata  out  8  write data to master.
- m_rdata  in  8  read data from master.
- m_done  in  1  master completion.

Behaviour:
- Reset (async): state=IDLE; rr_ptr=0; all outputs 0, including m_newd, m_wr, m_addr, m_wdata, resp_*, busy and grant_id. The master shares rst, so reset mid-transaction aborts both cleanly. No resp_valid is issued for the aborted command.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr, wrapping at NUM_REQ-1 -> 0.
  - Latch that requester's wr/addr/wdata into m_* registers and set grant_id -> ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle): assert m_newd; clear the watchdog counter; capture m_done as the edge-detect history -> WAIT.
- WAIT:
  - m_newd, m_wr, m_addr and m_wdata are held stable.
  - A rising edge of m_done (registered m_done was 0, current is 1) captures m_rdata if the command is a read, else 0. Then: resp_err=0, m_newd=0 -> RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without an edge: m_newd=0, resp_err=1, resp_rdata=0 -> RESP.
  - If done rises on the same cycle the counter expires, done wins (no error).
- RESP (1 cycle):
  - resp_valid[grant_id]=1.
  - rr_ptr = grant_id+1, wrapping to 0 after NUM_REQ-1 -> GAP.
- GAP: count GAP_CYCLES with m_newd=0 -> IDLE. Arbitration resumes in IDLE, so a granted requester with req still high is checked last.
- Command latency: winner's req seen in IDLE -> m_newd high 2 cycles later. Completion: m_done edge -> resp_valid 2 cycles later.
- Requests:
  - A request deasserted before grant is simply not considered.
  - A request deasserted after grant does not cancel the transaction; its response still pulses.
  - Inputs of non-granted requesters are ignored.
  - The requester must drop req the cycle after resp_valid, else it is re-arbitrated as a new request.
- resp_rdata and resp_err hold their value until the next RESP.
- Widths:
  - Watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates.
  - GAP counter is $clog2(GAP_CYCLES+1) bits.
  - rr_ptr wraps modulo NUM_REQ, including non-power-of-two values.

Decomposition:
- Shared package i2c_pkg holds:
  - I2C_ADDR_W=7 and I2C_DATA_W=8.
  - The FSM state enum (arb_state_t).
  - An i2c_cmd_t struct {wr, addr, data}.
- Sub-module rr_arbiter: combinational round-robin picker. Inputs are req and rr_ptr; outputs are grant_onehot, grant_idx and any_req. It is reusable elsewhere in the I2C subsystem.

Test Plan:
- Single write: req[0]=1, wr=1, addr=7'h10, wdata=8'h27; stub master raises m_done after 50 cycles -> m_newd high until the done edge, then resp_valid=4'b0001 with resp_err=0 and resp_rdata=0.
- Read: req[2]=1, wr=0, addr=7'h10; stub returns m_rdata=8'h27 with done -> resp_valid=4'b0100, resp_rdata=8'h27, m_wr=0 throughout.
- Contention: req=4'b1111 held in the same cycle from reset -> grants in order 0,1,2,3,0. Each m_newd rising edge is separated by at least GAP_CYCLES+2 cycles.
- Round-robin fairness: req[1] and req[3] continuously re-requesting -> grants alternate 1,3,1,3; no requester is starved over 20 transactions.
- Timeout: req[1] with m_done stuck 0 -> after TIMEOUT_CYCLES cycles in WAIT, m_newd=0, resp_valid=4'b0010, resp_err=1; the next request is then serviced normally.
- Reset mid-WAIT: assert rst asynchronously while m_newd=1 -> all outputs are 0 immediately with no resp_valid pulse. After release, a new req[0] is granted first.
